// File: rtl/approx_dot_accum.sv
// Streaming accumulator for approximate multiplier products: adds a bias-compensation constant
// per beat, sums frames of up to LEN beats and presents each frame sum over a valid/ready port.
module approx_dot_accum #(
    parameter int unsigned PW   = 16,
    parameter int unsigned LEN  = 8,
    parameter int unsigned CW   = $clog2(LEN + 1),
    parameter int unsigned AW   = 19,
    parameter int unsigned COMP = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [PW-1:0] in_prod_i,
    input  logic          in_last_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [AW-1:0] out_sum_o,
    output logic [CW-1:0] out_count_o
);

    // z is the product of two PW/2-bit operands, so it never exceeds (2^(PW/2)-1)^2.
    localparam longint unsigned MaxOp   = (64'd1 << (PW / 2)) - 64'd1;
    localparam longint unsigned MaxProd = MaxOp * MaxOp;
    localparam longint unsigned MaxSum  = 64'(LEN) * (MaxProd + 64'(COMP));
    localparam longint unsigned Limit   = 64'd1 << AW;

    if (LEN < 2 || MaxSum >= Limit) begin : g_param_check
        $fatal(1, "approx_dot_accum: LEN/AW/COMP combination can overflow the accumulator");
    end

    logic [AW-1:0] acc_q, acc_d;
    logic [AW-1:0] sum_q, sum_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] count_q, count_d;
    logic          valid_q, valid_d;
    logic [AW-1:0] beat_sum;
    logic          accept;
    logic          final_beat;

    assign in_ready_o  = !valid_q || out_ready_i;
    assign accept      = in_valid_i && in_ready_o;
    assign final_beat  = accept && (in_last_i || (cnt_q == CW'(LEN - 1)));
    assign beat_sum    = acc_q + AW'(in_prod_i) + AW'(COMP);

    assign out_valid_o = valid_q;
    assign out_sum_o   = sum_q;
    assign out_count_o = count_q;

    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        count_d = count_q;
        valid_d = valid_q;
        if (valid_q && out_ready_i) begin
            valid_d = 1'b0;
        end
        // A new result loading in the same cycle overrides the handshake clear.
        if (final_beat) begin
            sum_d   = beat_sum;
            count_d = cnt_q + CW'(1);
            valid_d = 1'b1;
            acc_d   = '0;
            cnt_d   = '0;
        end else if (accept) begin
            acc_d = beat_sum;
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: tb/tb_approx_dot_accum.sv
// Self-checking bench for approx_dot_accum: directed scenarios plus a randomized run checked
// against a frame-level reference model.
module tb_approx_dot_accum;

    localparam int unsigned LEN  = 8;
    localparam int unsigned COMP = 1;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_prod;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [18:0] out_sum;
    logic [3:0]  out_count;

    int n_checks;
    int n_fail;

    approx_dot_accum dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_prod_i   (in_prod),
        .in_last_i   (in_last),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_sum_o   (out_sum),
        .out_count_o (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: a frame's result is the plain sum of its products plus COMP per product.
    function automatic int unsigned frame_sum(input int unsigned p[$]);
        int unsigned s;
        s = 0;
        foreach (p[i]) s += p[i] + COMP;
        return s;
    endfunction

    task automatic beat(input int unsigned prod, input logic last);
        in_valid = 1'b1;
        in_prod  = prod[15:0];
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_sum !== 19'd0 || out_count !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%b sum=%0d count=%0d, required 0/0/0",
                     out_valid, out_sum, out_count);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_full_frame();
        int unsigned q[$];
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            q.push_back(100);
            beat(100, 1'b0);
            if (i == 6) begin
                n_checks++;
                if (out_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL full_frame_early: valid=%b after 7 beats, required 0", out_valid);
                end
            end
        end
        n_checks++;
        if (out_valid !== 1'b1 || out_sum !== 19'(frame_sum(q)) || out_count !== 4'd8) begin
            n_fail++;
            $display("FAIL full_frame: valid=%b sum=%0d count=%0d, required 1/%0d/8",
                     out_valid, out_sum, out_count, frame_sum(q));
        end
        idle();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL full_frame_drain: valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_short_frame();
        int unsigned q[$];
        out_ready = 1'b1;
        q = '{10, 20, 30};
        beat(10, 1'b0);
        beat(20, 1'b0);
        beat(30, 1'b1);
        n_checks++;
        if (out_valid !== 1'b1 || out_sum !== 19'(frame_sum(q)) || out_count !== 4'd3) begin
            n_fail++;
            $display("FAIL short_frame: valid=%b sum=%0d count=%0d, required 1/%0d/3",
                     out_valid, out_sum, out_count, frame_sum(q));
        end
        // Next frame must start from an empty accumulator.
        beat(0, 1'b1);
        n_checks++;
        if (out_valid !== 1'b1 || out_sum !== 19'(COMP) || out_count !== 4'd1) begin
            n_fail++;
            $display("FAIL short_frame_restart: valid=%b sum=%0d count=%0d, required 1/%0d/1",
                     out_valid, out_sum, out_count, COMP);
        end
        idle();
    endtask

    task automatic test_max_value();
        int unsigned q[$];
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            q.push_back(65025);
            beat(65025, (i == 7));
        end
        n_checks++;
        if (out_valid !== 1'b1 || out_sum !== 19'(frame_sum(q)) || out_count !== 4'd8
            || frame_sum(q) != 520208) begin
            n_fail++;
            $display("FAIL max_value: valid=%b sum=%0d count=%0d, required 1/520208/8",
                     out_valid, out_sum, out_count);
        end
        idle();
    endtask

    task automatic test_backpressure();
        int unsigned q[$];
        int unsigned exp;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            q.push_back(3);
            beat(3, 1'b0);
        end
        exp = frame_sum(q);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_prod  = 16'd7;
            in_last  = 1'b0;
            #1;
            n_checks++;
            if (in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL backpressure_ready: cycle %0d in_ready=%b, required 0", i, in_ready);
            end
            @(posedge clk);
            #1;
            n_checks++;
            if (out_valid !== 1'b1 || out_sum !== 19'(exp) || out_count !== 4'd8) begin
                n_fail++;
                $display("FAIL backpressure_hold: valid=%b sum=%0d count=%0d, required 1/%0d/8",
                         out_valid, out_sum, out_count, exp);
            end
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure_release: in_ready=%b, required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure_accept: valid=%b, required 0", out_valid);
        end
        // The release-cycle beat was the first of a new frame; seven more complete it.
        q.delete();
        for (int i = 0; i < 8; i++) q.push_back(7);
        for (int i = 0; i < 7; i++) beat(7, 1'b0);
        n_checks++;
        if (out_valid !== 1'b1 || out_sum !== 19'(frame_sum(q)) || out_count !== 4'd8) begin
            n_fail++;
            $display("FAIL backpressure_resume: valid=%b sum=%0d count=%0d, required 1/%0d/8",
                     out_valid, out_sum, out_count, frame_sum(q));
        end
        idle();
    endtask

    task automatic test_back_to_back();
        int unsigned prods[3];
        prods = '{5, 7, 9};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            beat(prods[i], 1'b1);
            in_valid = 1'b1;
            n_checks++;
            if (out_valid !== 1'b1 || out_sum !== 19'(prods[i] + COMP) || out_count !== 4'd1) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: valid=%b sum=%0d count=%0d, required 1/%0d/1",
                         i, out_valid, out_sum, out_count, prods[i] + COMP);
            end
        end
        idle();
    endtask

    task automatic test_reset_mid_frame();
        int unsigned q[$];
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) beat(50, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_sum !== 19'd0 || out_count !== 4'd0 || in_ready !== 1'b1)
        begin
            n_fail++;
            $display("FAIL reset_mid_frame: valid=%b sum=%0d count=%0d ready=%b, required 0/0/0/1",
                     out_valid, out_sum, out_count, in_ready);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            q.push_back(1);
            beat(1, 1'b0);
        end
        n_checks++;
        if (out_valid !== 1'b1 || out_sum !== 19'(frame_sum(q)) || out_count !== 4'd8) begin
            n_fail++;
            $display("FAIL reset_restart: valid=%b sum=%0d count=%0d, required 1/%0d/8",
                     out_valid, out_sum, out_count, frame_sum(q));
        end
        idle();
    endtask

    task automatic test_random();
        int unsigned frame[$];
        int unsigned pend_sum;
        int unsigned pend_cnt;
        int unsigned prod;
        logic        pend;
        logic        ready_m;
        int          errs;
        pend = 1'b0;
        pend_sum = 0;
        pend_cnt = 0;
        errs = 0;
        for (int c = 0; c < 400; c++) begin
            prod      = ($urandom_range(0, 7) == 0) ? 65025 : $urandom_range(0, 65025);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_last   = ($urandom_range(0, 4) == 0);
            in_prod   = prod[15:0];
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            ready_m = !pend || out_ready;
            n_checks++;
            if (out_valid !== pend || in_ready !== ready_m
                || (pend && (out_sum !== 19'(pend_sum) || out_count !== 4'(pend_cnt)))) begin
                n_fail++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random[%0d]: valid=%b ready=%b sum=%0d count=%0d, required %b/%b/%0d/%0d",
                             c, out_valid, in_ready, out_sum, out_count, pend, ready_m,
                             pend_sum, pend_cnt);
            end
            if (pend && out_ready) pend = 1'b0;
            if (in_valid && ready_m) begin
                frame.push_back(prod);
                if (in_last || frame.size() == LEN) begin
                    pend_sum = frame_sum(frame);
                    pend_cnt = frame.size();
                    pend     = 1'b1;
                    frame.delete();
                end
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        in_valid  = 1'b0;
        in_prod   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_full_frame();
        test_short_frame();
        test_max_value();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
